// File: rtl/fuzzy_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Package : fuzzy_pkg                                                        |
// | Shared widths, data typedefs and scheduler state encoding.                 |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package fuzzy_pkg;

    localparam int c_NUM_CH   = 4;
    localparam int c_IN_W     = 4;
    localparam int c_LONG_W   = 10;
    localparam int c_NUM_SETS = 3;

    typedef logic [c_IN_W-1:0]   sample_t;
    typedef logic [c_LONG_W-1:0] degree_t;
    typedef logic [2:0]          partFlag_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MAP  = 2'd1,
        ST_OUT  = 2'd2
    } state_t;

endpackage : fuzzy_pkg
`default_nettype wire

// File: rtl/fuzzy_map_scheduler_rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : rr_arbiter                                                       |
// | Round-robin arbiter; search starts one past the last granted channel.      |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_arbiter #(
    parameter int NUM_CH = 4,
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] i_req,
    input  logic              i_advance,
    output logic [NUM_CH-1:0] o_grant,
    output logic [IDX_W-1:0]  o_grantIdx,
    output logic              o_anyReq
);

    logic [IDX_W-1:0] r_ptr;
    logic             w_found;
    int               w_sum;

    always_comb begin
        w_found    = 1'b0;
        w_sum      = 0;
        o_grantIdx = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_sum = (int'(r_ptr) + i) % NUM_CH;
            if (!w_found && i_req[w_sum]) begin
                w_found    = 1'b1;
                o_grantIdx = IDX_W'(w_sum);
            end
        end
        o_grant = w_found ? (NUM_CH'(1) << o_grantIdx) : '0;
    end

    assign o_anyReq = |i_req;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr <= '0;
        end else if (i_advance) begin
            r_ptr <= (o_grantIdx == IDX_W'(NUM_CH - 1)) ? '0 : o_grantIdx + 1'b1;
        end
    end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/fuzzy_map_scheduler.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : fuzzy_map_scheduler                                              |
// | Time-shares one combinational fuzzy-mapping datapath among sensor channels.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fuzzy_map_scheduler
    import fuzzy_pkg::*;
#(
    parameter int NUM_CH   = c_NUM_CH,
    parameter int IN_W     = c_IN_W,
    parameter int LONG_W   = c_LONG_W,
    parameter int NUM_SETS = c_NUM_SETS,
    localparam int CH_W    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int SET_W   = (NUM_SETS > 1) ? $clog2(NUM_SETS) : 1
) (
    input  logic                       Clk,
    input  logic                       Rst,
    input  logic [NUM_CH-1:0]          ReqValid,
    input  logic [NUM_CH*IN_W-1:0]     ReqData,
    output logic [NUM_CH-1:0]          ReqReady,
    output logic [IN_W-1:0]            MapInFixed,
    output logic [SET_W-1:0]           MapSetSel,
    input  logic [2:0]                 MapLocalFlag,
    input  logic [LONG_W-1:0]          MapLongBit,
    input  logic                       MapError,
    output logic                       OutValid,
    input  logic                       OutReady,
    output logic [CH_W-1:0]            OutChan,
    output logic [NUM_SETS*3-1:0]      OutFlags,
    output logic [NUM_SETS*LONG_W-1:0] OutDegree,
    output logic                       OutError
);

    state_t                     r_state;
    state_t                     w_nextState;
    logic [IN_W-1:0]            r_sample;
    logic [SET_W-1:0]           r_setIdx;
    logic [CH_W-1:0]            r_chan;
    logic [NUM_SETS*3-1:0]      r_flags;
    logic [NUM_SETS*LONG_W-1:0] r_degree;
    logic                       r_err;
    logic [NUM_CH-1:0]          w_grant;
    logic [CH_W-1:0]            w_grantIdx;
    logic                       w_anyReq;
    logic                       w_accept;
    logic                       w_lastSet;

    rr_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arbiter (
        .clk        (Clk),
        .rst        (Rst),
        .i_req      (ReqValid),
        .i_advance  (w_accept),
        .o_grant    (w_grant),
        .o_grantIdx (w_grantIdx),
        .o_anyReq   (w_anyReq)
    );

    assign w_lastSet = (r_setIdx == SET_W'(NUM_SETS - 1));

    // Every output is forced quiet while Rst is high, whatever the current state.
    always_comb begin
        w_nextState = r_state;
        w_accept    = 1'b0;
        ReqReady    = '0;
        OutValid    = 1'b0;
        MapInFixed  = '0;
        MapSetSel   = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_anyReq) begin
                    w_nextState = ST_MAP;
                    w_accept    = !Rst;
                    ReqReady    = Rst ? '0 : w_grant;
                end
            end
            ST_MAP: begin
                MapInFixed = Rst ? '0 : r_sample;
                MapSetSel  = Rst ? '0 : r_setIdx;
                if (w_lastSet) begin
                    w_nextState = ST_OUT;
                end
            end
            ST_OUT: begin
                OutValid = !Rst;
                if (OutReady) begin
                    w_nextState = ST_IDLE;
                end
            end
            default: begin
                w_nextState = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_nextState;
        end
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_sample <= '0;
            r_setIdx <= '0;
            r_chan   <= '0;
            r_flags  <= '0;
            r_degree <= '0;
            r_err    <= 1'b0;
        end else if (w_accept) begin
            r_sample <= ReqData[int'(w_grantIdx)*IN_W +: IN_W];
            r_chan   <= w_grantIdx;
            r_setIdx <= '0;
            r_flags  <= '0;
            r_degree <= '0;
            r_err    <= 1'b0;
        end else if (r_state == ST_MAP) begin
            // Flags are kept raw: boundary points may legitimately set two bits.
            r_flags[int'(r_setIdx)*3 +: 3]       <= MapLocalFlag;
            r_degree[int'(r_setIdx)*LONG_W +: LONG_W] <= MapLongBit;
            r_err <= r_err | MapError;
            if (!w_lastSet) begin
                r_setIdx <= r_setIdx + 1'b1;
            end
        end
    end

    assign OutChan   = r_chan;
    assign OutFlags  = r_flags;
    assign OutDegree = r_degree;
    assign OutError  = r_err;

endmodule : fuzzy_map_scheduler
`default_nettype wire
